// File: rtl/vec_queue_arbiter.sv
// vec_queue_arbiter: round-robin packet arbiter sharing one val/rdy queue among NUM_REQ requesters
module vec_queue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ*WIDTH-1:0] req_msg,
  input  logic [NUM_REQ-1:0]       req_val,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic [WIDTH-1:0]         send_msg,
  output logic [ID_W-1:0]          send_src,
  output logic                     send_last,
  output logic                     send_val,
  input  logic                     send_rdy,
  output logic                     grant_active,
  output logic [ID_W-1:0]          grant_id
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t          fsm_q, fsm_d;
  logic [ID_W-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, sel, sel_inc;
  logic            any, own_val, fire, done;
  // pick the requester: rotating scan from rr_ptr when idle, the locked owner otherwise
  always_comb begin
    sel     = '0;
    own_val = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      for (int i = 0; i < NUM_REQ; i++)
        if (i == (int'(rr_ptr_q) + k) % NUM_REQ && req_val[i]) sel = ID_W'(i);
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == owner_q) own_val = req_val[i];
    if (fsm_q == LOCKED) sel = owner_q;
    any     = !reset && ((fsm_q == LOCKED) ? own_val : |req_val);
    sel_inc = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
  end
  // forward the selected beat and steer ready back to its requester only
  always_comb begin
    send_msg  = '0;
    send_last = 1'b0;
    req_rdy   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel) begin
        send_msg  = req_msg[i*WIDTH +: WIDTH];
        send_last = req_last[i];
      end
      req_rdy[i] = any && send_rdy && ID_W'(i) == sel;
    end
    send_val = any;
    send_src = sel;
  end
  // next state: lock on a stalled or non-final beat, release and rotate when the last beat is taken
  always_comb begin
    fire     = send_val && send_rdy;
    done     = fire && send_last;
    fsm_d    = done ? IDLE : (fsm_q == LOCKED || any) ? LOCKED : IDLE;
    owner_d  = (fsm_q == IDLE && any && !done) ? sel : owner_q;
    rr_ptr_d = done ? sel_inc : rr_ptr_q;
  end
  // arbitration state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign grant_active = (fsm_q == LOCKED);
  assign grant_id     = owner_q;
endmodule

// File: tb/tb_vec_queue_arbiter.sv
// tb_vec_queue_arbiter: directed and random checks of vec_queue_arbiter against a packet-level model
module tb_vec_queue_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] msg4 = '0;
  logic [3:0]  val4 = '0, last4 = '0, rr4;
  logic        rdy4 = 1'b0, slast4, sval4, ga4;
  logic [7:0]  smsg4, smsg3;
  logic [1:0]  src4, gid4, src3, gid3;
  logic [23:0] msg3 = '0;
  logic [2:0]  val3 = '0, last3 = '0, rr3;
  logic        rdy3 = 1'b0, slast3, sval3, ga3;
  int          total = 0, bad = 0;
  int          m_own [2];
  int          m_ptr [2];
  logic [1:0]  obs_src;
  logic        obs_ga;
  logic [3:0]  obs_rr;
  always #5 clk = ~clk;
  vec_queue_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .req_msg(msg4), .req_val(val4), .req_last(last4), .req_rdy(rr4),
    .send_msg(smsg4), .send_src(src4), .send_last(slast4), .send_val(sval4), .send_rdy(rdy4),
    .grant_active(ga4), .grant_id(gid4));
  vec_queue_arbiter #(.NUM_REQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .req_msg(msg3), .req_val(val3), .req_last(last3), .req_rdy(rr3),
    .send_msg(smsg3), .send_src(src3), .send_last(slast3), .send_val(sval3), .send_rdy(rdy3),
    .grant_active(ga3), .grant_id(gid3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_own = '{-1, -1};
    m_ptr = '{0, 0};
  endtask
  // one cycle: compare outputs at negedge against the packet model, then advance the model at posedge
  task automatic step(input int inst);
    int n, sel;
    logic any, rdy, sl, sv, ga;
    logic [3:0] v, l, rr;
    logic [31:0] m;
    logic [7:0] smsg;
    logic [1:0] src, gid;
    @(negedge clk);
    if (inst == 0) begin
      n = 4; v = val4; l = last4; m = msg4; rdy = rdy4;
      rr = rr4; smsg = smsg4; src = src4; sl = slast4; sv = sval4; ga = ga4; gid = gid4;
    end else begin
      n = 3; v = {1'b0, val3}; l = {1'b0, last3}; m = {8'h00, msg3}; rdy = rdy3;
      rr = {1'b0, rr3}; smsg = smsg3; src = src3; sl = slast3; sv = sval3; ga = ga3; gid = gid3;
    end
    obs_src = src; obs_ga = ga; obs_rr = rr;
    sel = -1;
    if (m_own[inst] >= 0) begin
      sel = m_own[inst];
      any = v[sel];
    end else begin
      for (int k = 0; k < n; k++)
        if (sel < 0 && v[(m_ptr[inst] + k) % n]) sel = (m_ptr[inst] + k) % n;
      any = sel >= 0;
    end
    chk("send_val", sv, any);
    chk("req_rdy", rr, (any && rdy) ? (1 << sel) : 0);
    chk("grant_active", ga, m_own[inst] >= 0);
    if (m_own[inst] >= 0) chk("grant_id", gid, m_own[inst]);
    if (any) begin
      chk("send_src", src, sel);
      chk("send_msg", smsg, m[sel*8 +: 8]);
      chk("send_last", sl, l[sel]);
    end
    @(posedge clk);
    if (any && rdy && l[sel]) begin
      m_ptr[inst] = (sel + 1) % n;
      m_own[inst] = -1;
    end else if (any && m_own[inst] < 0) m_own[inst] = sel;
    #1;
  endtask
  task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic [31:0] m, input logic r);
    val4 = v; last4 = l; msg4 = m; rdy4 = r;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send_val", sval4, 1'b0);
    chk("rst_req_rdy", rr4, 4'b0000);
    chk("rst_grant_active", ga4, 1'b0);
    chk("rst_grant_id", gid4, 2'd0);
    reset = 1'b0;
    drive4(4'b0000, 4'b0000, 32'h0, 1'b1);
    repeat (5) step(0);
    drive4(4'b1111, 4'b1111, 32'h44332211, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(0);
      chk("rr_seq_src", obs_src, k % 4);
      chk("rr_seq_ga", obs_ga, 1'b0);
    end
    drive4(4'b0011, 4'b0011, 32'h0000BBAA, 1'b1);
    repeat (2) step(0);
    drive4(4'b0101, 4'b0000, 32'h00A10010, 1'b1);
    step(0);
    chk("pkt_b1_src", obs_src, 2'd2);
    chk("pkt_b1_ga", obs_ga, 1'b0);
    drive4(4'b0101, 4'b0000, 32'h00A20010, 1'b1);
    step(0);
    chk("pkt_b2_src", obs_src, 2'd2);
    chk("pkt_b2_ga", obs_ga, 1'b1);
    chk("pkt_b2_rdy0", obs_rr[0], 1'b0);
    drive4(4'b0101, 4'b0100, 32'h00A30010, 1'b1);
    step(0);
    chk("pkt_b3_src", obs_src, 2'd2);
    chk("pkt_b3_ga", obs_ga, 1'b1);
    drive4(4'b0001, 4'b0001, 32'h00000010, 1'b1);
    step(0);
    chk("pkt_next_src", obs_src, 2'd0);
    drive4(4'b0010, 4'b0010, 32'h00005500, 1'b0);
    step(0);
    chk("stall_c1_src", obs_src, 2'd1);
    drive4(4'b1010, 4'b1010, 32'h33005500, 1'b0);
    repeat (2) begin
      step(0);
      chk("stall_src", obs_src, 2'd1);
    end
    drive4(4'b1010, 4'b1010, 32'h33005500, 1'b1);
    step(0);
    chk("stall_accept_rdy", obs_rr, 4'b0010);
    drive4(4'b1000, 4'b1000, 32'h33000000, 1'b1);
    step(0);
    chk("after_stall_src", obs_src, 2'd3);
    drive4(4'b1000, 4'b0000, 32'h77000000, 1'b1);
    repeat (2) step(0);
    chk("locked3_gid", gid4, 2'd3);
    reset = 1'b1;
    #1;
    chk("midrst_send_val", sval4, 1'b0);
    chk("midrst_ga", ga4, 1'b0);
    chk("midrst_rdy", rr4, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive4(4'b1111, 4'b1111, 32'h44332211, 1'b1);
    step(0);
    chk("postrst_src", obs_src, 2'd0);
    for (int c = 0; c < 400; c++) begin
      drive4(4'($urandom), 4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
      step(0);
    end
    drive4(4'b0000, 4'b0000, 32'h0, 1'b1);
    val3 = 3'b111; last3 = 3'b111; msg3 = 24'hCCBBAA; rdy3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("n3_seq_src", obs_src, k % 3);
    end
    for (int c = 0; c < 300; c++) begin
      val3 = 3'($urandom); last3 = 3'($urandom); msg3 = 24'($urandom);
      rdy3 = 1'($urandom_range(0, 3) != 0);
      step(1);
      if (obs_rr != 0) chk("n3_src_range", obs_src < 2'd3, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
